mvm_seq_ctrl: RTL and testbench
===============================

Name: mvm_seq_ctrl

Overview:
Sequencing controller for the matrix-vector multiplier. It computes Y = W·x + B with a single shared multiply-accumulate unit, one row at a time.
- x is captured through a streaming handshake.
- W and B are read from external synchronous memories.
- Each Y element is emitted through a valid/ready output stream.
- It sits between the host/DMA side (start, x stream, Y stream) and the coefficient memories.

Parameters:
N, 2, number of inputs (columns of W, length of x); N ≥ 1
M, 3, number of outputs (rows of W, length of Y/B); M ≥ 1
XW, 8, width of x elements (unsigned)
WW, 8, width of W elements (unsigned)
YW, 16, width of accumulator, B elements and Y elements (unsigned)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begins a job when idle
busy  out  1  high from start accept until the done cycle inclusive
done  out  1  one-cycle pulse after the last Y element handshakes
x_valid  in  1  x element valid
x_ready  out  1  controller accepts x element
x_data  in  XW  x element, index order 0..N-1
w_rd_en  out  1  weight/bias memory read enable
w_addr  out  clog2(M*N) (min 1)  weight address = row*N + col
w_rdata  in  WW  weight data, valid exactly 1 cycle after w_rd_en
b_addr  out  clog2(M) (min 1)  bias address = row; read under w_rd_en
b_rdata  in  YW  bias data, valid 1 cycle after w_rd_en
y_valid  out  1  Y element valid
y_ready  in  1  downstream accepts Y element
y_data  out  YW  Y element
y_idx  out  clog2(M) (min 1)  row index of y_data

Behaviour:
- Reset (async assert, sync release): state IDLE. busy, done, x_ready, w_rd_en, y_valid all 0. w_addr, b_addr, y_data, y_idx, accumulator, x buffer, and row/col counters are all 0.
- IDLE: start=1 → LOAD_X, busy=1, col=0. start is ignored in every other state.
- LOAD_X: x_ready=1.
  - Each x_valid & x_ready stores x_data into xbuf[col] and increments col.
  - After element N-1 is accepted: col=0, row=0 → MAC.
  - x_valid outside LOAD_X is ignored (x_ready=0).
- MAC (per row, N+1 cycles):
  - Cycles k=0..N-1: w_rd_en=1, w_addr=row*N+k, b_addr=row.
  - Cycle k=1: acc ← b_rdata.
  - Cycles k=1..N: acc ← acc_sel + xbuf[k-1]*w_rdata, where acc_sel = b_rdata on k=1, otherwise acc.
  - Cycle N: w_rd_en=0. Next state OUT, with y_data = final acc.
  - N=1 is legal: issue cycle, then accumulate cycle.
- Arithmetic:
  - Product width is XW+WW, zero-extended or truncated to YW.
  - Sum is modulo 2^YW; no saturation, no overflow flag.
- OUT:
  - y_valid=1, y_idx=row. y_data and y_idx are held stable while y_valid & !y_ready, for any stall length.
  - On handshake: if row==M-1 → DONE; else row+1 → MAC, with the next read issued the cycle after the handshake.
- DONE: done=1 and busy=1 for one cycle → IDLE, where busy=0. A start in the DONE cycle is ignored.
- Latency (y_ready held 1): first y_valid appears N+1 cycles after the MAC entry cycle. Per row: N+1 MAC cycles + 1 OUT cycle.
- Reset mid-operation: immediate return to IDLE. All outputs go to reset values and no partial Y is emitted.
- w_rdata and b_rdata are sampled only in the cycle after w_rd_en=1. At other times they are don't-care.

Decomposition:
- Shared package mvm_pkg holds:
  - state enum {IDLE, LOAD_X, MAC, OUT, DONE};
  - default width constants XW, WW, YW;
  - address-width helper function (clog2 with min 1).
- One sub-module, mvm_mac: accumulator register with init-from-bias and multiply-add. Controls are init, en, and operands x, w, b. It is parameterized by XW, WW, YW and has async active-high rst.
- FSM, counters and x buffer live in mvm_seq_ctrl.

Test Plan:
- Nominal job:
  - Stimulus: N=2, M=3, x=[1,2], W=[[2,3],[4,5],[6,7]], B=[1,1,1], y_ready=1.
  - Required response: Y stream (idx,data) = (0,9),(1,15),(2,21). done pulses once, in the cycle after the third handshake. Exact read-address order is 0,1,2,3,4,5.
- Back-pressure:
  - Stimulus: same job, y_ready=0 for 5 cycles on row 1.
  - Required response: y_valid stays high with y_data=15, y_idx=1 stable throughout. No reads are issued during the stall. Final Y is unchanged.
- Overflow wrap:
  - Stimulus: x=[255,255], all W=255, B=1.
  - Required response: every y_data = 64515, i.e. (2·65025+1) mod 65536.
- Start/x protocol:
  - Stimulus: x_valid gapped (1 high, 3 low, 1 high); start pulsed during MAC; x_valid asserted during OUT.
  - Required response: both x elements are captured correctly. The extra start and the stray x_valid are ignored, so exactly 3 outputs are produced.
- Reset mid-operation:
  - Stimulus: assert rst during row 1 MAC, then run the nominal job.
  - Required response: all outputs are 0 while rst is high. The following job produces exactly 9, 15, 21 with no stale values.
- N=1, M=1:
  - Stimulus: x=[3], W=[[4]], B=[5].
  - Required response: single y_data=17, y_idx=0, then done.

Source files
------------

// File: rtl/mvm_pkg.sv
// -----------------------------------------------------------------------------
// mvm_pkg
// Shared definitions for the matrix-vector multiplier sequencer:
//   - state_e     : controller state encoding
//   - MVM_XW/WW/YW: default element widths (x, W, accumulator/B/Y)
//   - addr_w()    : address width for a given depth, never less than 1 bit
// -----------------------------------------------------------------------------
package mvm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_X = 3'd1,
        MAC    = 3'd2,
        OUT    = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int MVM_XW = 8;
    localparam int MVM_WW = 8;
    localparam int MVM_YW = 16;

    // Width needed to address 'depth' entries; a single entry still gets one bit.
    function automatic int addr_w(input int depth);
        if (depth <= 1) begin
            return 1;
        end else begin
            return $clog2(depth);
        end
    endfunction

endpackage

// File: rtl/mvm_mac.sv
// -----------------------------------------------------------------------------
// mvm_mac
// Single multiply-accumulate register.
//   clk, rst : clock, asynchronous active-high reset (acc -> 0)
//   init_i   : use b_i instead of the held accumulator as the addend
//   en_i     : update the accumulator this cycle
//   x_i, w_i : unsigned operands, product zero-extended/truncated to YW
//   b_i      : bias operand used on init
//   acc_o    : accumulator value (modulo 2^YW, no saturation)
// -----------------------------------------------------------------------------
module mvm_mac #(
    parameter int XW = 8,
    parameter int WW = 8,
    parameter int YW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_i,
    input  logic          en_i,
    input  logic [XW-1:0] x_i,
    input  logic [WW-1:0] w_i,
    input  logic [YW-1:0] b_i,
    output logic [YW-1:0] acc_o
);

    // Product is formed at least YW wide so the low YW bits are exact in both
    // the widening and the truncating case.
    localparam int PW = ((XW + WW) > YW) ? (XW + WW) : YW;

    logic [PW-1:0] prod_s;
    logic [YW-1:0] base_s;
    logic [YW-1:0] acc_d;
    logic [YW-1:0] acc_q;

    assign prod_s = PW'(x_i) * PW'(w_i);
    assign base_s = init_i ? b_i : acc_q;
    assign acc_d  = base_s + prod_s[YW-1:0];
    assign acc_o  = acc_q;

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= {YW{1'b0}};
        end else if (en_i) begin
            acc_q <= acc_d;
        end else begin
            acc_q <= acc_q;
        end
    end

endmodule

// File: rtl/mvm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mvm_seq_ctrl
// Sequencer computing Y = W*x + B one row at a time on one shared MAC.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin a job (accepted in IDLE only)
//   busy, done        : job in progress / one-cycle completion pulse
//   x_valid/ready/data: x element stream, index order 0..N-1
//   w_rd_en, w_addr   : weight read (address row*N+col), data 1 cycle later
//   w_rdata           : weight data
//   b_addr, b_rdata   : bias read (address row) under w_rd_en, data 1 cycle later
//   y_valid/ready     : Y element stream handshake
//   y_data, y_idx     : Y element and its row index, stable while stalled
// -----------------------------------------------------------------------------
module mvm_seq_ctrl
    import mvm_pkg::*;
#(
    parameter  int N  = 2,
    parameter  int M  = 3,
    parameter  int XW = MVM_XW,
    parameter  int WW = MVM_WW,
    parameter  int YW = MVM_YW,
    localparam int AW = addr_w(M * N),
    localparam int BW = addr_w(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [XW-1:0] x_data,
    output logic          w_rd_en,
    output logic [AW-1:0] w_addr,
    input  logic [WW-1:0] w_rdata,
    output logic [BW-1:0] b_addr,
    input  logic [YW-1:0] b_rdata,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [YW-1:0] y_data,
    output logic [BW-1:0] y_idx
);

    // col counts x elements in LOAD_X and MAC sub-cycles k = 0..N in MAC.
    localparam int CW = addr_w(N + 1);
    localparam int XI = addr_w(N);

    state_e        state_q;
    logic [CW-1:0] col_q;
    logic [BW-1:0] row_q;
    logic [XW-1:0] xbuf_q [N];
    logic          busy_q;
    logic          done_q;
    logic          x_ready_q;
    logic          w_rd_en_q;
    logic [AW-1:0] w_addr_q;
    logic          y_valid_q;

    logic          mac_en_s;
    logic          mac_init_s;
    logic [XI-1:0] kidx_s;
    logic [YW-1:0] acc_s;

    // Data read in sub-cycle k-1 arrives in sub-cycle k and pairs with x[k-1];
    // the first arrival (k=1) also seeds the accumulator with the bias.
    assign kidx_s     = XI'(col_q - CW'(1));
    assign mac_en_s   = (state_q == MAC) && (col_q != {CW{1'b0}});
    assign mac_init_s = (state_q == MAC) && (col_q == CW'(1));

    mvm_mac #(
        .XW (XW),
        .WW (WW),
        .YW (YW)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .init_i (mac_init_s),
        .en_i   (mac_en_s),
        .x_i    (xbuf_q[kidx_s]),
        .w_i    (w_rdata),
        .b_i    (b_rdata),
        .acc_o  (acc_s)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign x_ready = x_ready_q;
    assign w_rd_en = w_rd_en_q;
    assign w_addr  = w_addr_q;
    assign b_addr  = row_q;
    assign y_valid = y_valid_q;
    assign y_idx   = row_q;
    // Accumulator is frozen outside MAC, so it holds Y stable through stalls.
    assign y_data  = acc_s;

    // Controller FSM with counters, x buffer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= {CW{1'b0}};
            row_q     <= {BW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            x_ready_q <= 1'b0;
            w_rd_en_q <= 1'b0;
            w_addr_q  <= {AW{1'b0}};
            y_valid_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                xbuf_q[i] <= {XW{1'b0}};
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= LOAD_X;
                        busy_q    <= 1'b1;
                        x_ready_q <= 1'b1;
                        col_q     <= {CW{1'b0}};
                    end
                end
                LOAD_X: begin
                    if (x_valid && x_ready_q) begin
                        xbuf_q[XI'(col_q)] <= x_data;
                        if (col_q == CW'(N - 1)) begin
                            state_q   <= MAC;
                            col_q     <= {CW{1'b0}};
                            row_q     <= {BW{1'b0}};
                            x_ready_q <= 1'b0;
                            w_rd_en_q <= 1'b1;
                            w_addr_q  <= {AW{1'b0}};
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                MAC: begin
                    if (col_q == CW'(N)) begin
                        state_q   <= OUT;
                        col_q     <= {CW{1'b0}};
                        y_valid_q <= 1'b1;
                    end else begin
                        col_q <= col_q + CW'(1);
                        // k = N-1 is the last issue cycle of the row.
                        if (col_q == CW'(N - 1)) begin
                            w_rd_en_q <= 1'b0;
                        end else begin
                            w_addr_q <= w_addr_q + AW'(1);
                        end
                    end
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid_q <= 1'b0;
                        if (row_q == BW'(M - 1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // w_addr still holds row*N+N-1, so +1 starts the next row.
                            state_q   <= MAC;
                            row_q     <= row_q + BW'(1);
                            w_rd_en_q <= 1'b1;
                            w_addr_q  <= w_addr_q + AW'(1);
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    x_ready_q <= 1'b0;
                    w_rd_en_q <= 1'b0;
                    y_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mvm_seq_ctrl
// Directed bench for mvm_seq_ctrl: a table of jobs (x, W, B, expected Y) for the
// default N=2/M=3 instance, hand sequences for back-pressure, protocol noise and
// mid-job reset, and a second N=1/M=1 instance.
// -----------------------------------------------------------------------------
module tb_mvm_seq_ctrl;

    typedef struct packed {
        logic [7:0]       x0;
        logic [7:0]       x1;
        logic [5:0][7:0]  w;
        logic [2:0][15:0] b;
        logic [2:0][15:0] y;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start, busy, done;
    logic        x_valid, x_ready;
    logic [7:0]  x_data;
    logic        w_rd_en;
    logic [2:0]  w_addr;
    logic [7:0]  w_rdata;
    logic [1:0]  b_addr;
    logic [15:0] b_rdata;
    logic        y_valid, y_ready;
    logic [15:0] y_data;
    logic [1:0]  y_idx;

    logic        s_start, s_busy, s_done;
    logic        s_x_valid, s_x_ready;
    logic [7:0]  s_x_data;
    logic        s_w_rd_en;
    logic [0:0]  s_w_addr;
    logic [7:0]  s_w_rdata;
    logic [0:0]  s_b_addr;
    logic [15:0] s_b_rdata;
    logic        s_y_valid, s_y_ready;
    logic [15:0] s_y_data;
    logic [0:0]  s_y_idx;

    logic [7:0]  wmem [6];
    logic [15:0] bmem [3];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int s_rd_cnt = 0;

    int          rd_addr_q [$];
    int          rd_cyc_q  [$];
    logic [15:0] hs_data_q [$];
    int          hs_idx_q  [$];
    int          hs_cyc_q  [$];
    int          done_cyc_q[$];

    vec_t vecs [3];

    mvm_seq_ctrl #(.N(2), .M(3), .XW(8), .WW(8), .YW(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .b_addr(b_addr), .b_rdata(b_rdata),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_idx(y_idx)
    );

    mvm_seq_ctrl #(.N(1), .M(1), .XW(8), .WW(8), .YW(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .x_valid(s_x_valid), .x_ready(s_x_ready), .x_data(s_x_data),
        .w_rd_en(s_w_rd_en), .w_addr(s_w_addr), .w_rdata(s_w_rdata),
        .b_addr(s_b_addr), .b_rdata(s_b_rdata),
        .y_valid(s_y_valid), .y_ready(s_y_ready), .y_data(s_y_data), .y_idx(s_y_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous coefficient memories; garbage when not read so stray sampling shows.
    always @(posedge clk) begin
        if (w_rd_en) begin
            w_rdata <= wmem[w_addr];
            b_rdata <= bmem[b_addr];
        end else begin
            w_rdata <= 8'hA5;
            b_rdata <= 16'h5A5A;
        end
        if (s_w_rd_en && s_w_addr == 1'b0 && s_b_addr == 1'b0) begin
            s_w_rdata <= 8'd4;
            s_b_rdata <= 16'd5;
        end else begin
            s_w_rdata <= 8'hA5;
            s_b_rdata <= 16'h5A5A;
        end
    end

    // Mid-cycle monitor of reads, Y handshakes and done pulses.
    always @(negedge clk) begin
        if (w_rd_en) begin
            rd_addr_q.push_back(int'(w_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (y_valid && y_ready) begin
            hs_data_q.push_back(y_data);
            hs_idx_q.push_back(int'(y_idx));
            hs_cyc_q.push_back(cyc);
        end
        if (done) done_cyc_q.push_back(cyc);
        if (s_w_rd_en) s_rd_cnt <= s_rd_cnt + 1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_x(input logic [7:0] val, input string tag);
        bit ok;
        ok = 1'b0;
        x_valid = 1'b1;
        x_data  = val;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (x_ready) ok = 1'b1;
            tick();
        end
        chk({tag, "_x_accept"}, ok, 1);
    endtask

    task automatic run_job(input vec_t v, input int stall_row, input int stall_len,
                           input bit gap_x, input bit disturb, input string tag);
        int rd0, hs0, dn0, stalled, nh, nr;
        bit seen, sent_s, sent_x;
        rd0 = rd_addr_q.size(); hs0 = hs_data_q.size(); dn0 = done_cyc_q.size();
        for (int i = 0; i < 6; i++) wmem[i] = v.w[i];
        for (int i = 0; i < 3; i++) bmem[i] = v.b[i];
        y_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_start"}, busy, 1);
        feed_x(v.x0, tag);
        if (gap_x) begin
            x_valid = 1'b0;
            repeat (3) tick();
        end
        feed_x(v.x1, tag);
        x_valid = 1'b0;
        seen = 1'b0; stalled = 0; sent_s = 1'b0; sent_x = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            tick();
            start = 1'b0; x_valid = 1'b0; y_ready = 1'b1;
            if (done) begin
                seen = 1'b1;
                chk({tag, "_busy_in_done"}, busy, 1);
            end else begin
                if (y_valid && int'(y_idx) == stall_row && stalled < stall_len) begin
                    y_ready = 1'b0;
                    stalled++;
                    chk({tag, "_stall_y_data"}, y_data, v.y[stall_row]);
                    chk({tag, "_stall_y_idx"}, y_idx, stall_row);
                    chk({tag, "_stall_no_read"}, w_rd_en, 0);
                end
                if (disturb && w_rd_en && !sent_s) begin
                    start = 1'b1; sent_s = 1'b1;
                end
                if (disturb && y_valid && !sent_x) begin
                    x_valid = 1'b1; x_data = 8'hEE; sent_x = 1'b1;
                    chk({tag, "_x_ready_in_out"}, x_ready, 0);
                end
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        tick();
        x_valid = 1'b0; start = 1'b0;
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_done_after"}, done, 0);
        repeat (4) tick();
        nh = hs_data_q.size() - hs0;
        nr = rd_addr_q.size() - rd0;
        chk({tag, "_y_count"}, nh, 3);
        for (int r = 0; r < 3; r++) begin
            if (r < nh) begin
                chk({tag, "_y_data"}, hs_data_q[hs0 + r], v.y[r]);
                chk({tag, "_y_idx"}, hs_idx_q[hs0 + r], r);
            end
        end
        chk({tag, "_rd_count"}, nr, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < nr) chk({tag, "_rd_addr"}, rd_addr_q[rd0 + i], i);
        end
        chk({tag, "_done_count"}, done_cyc_q.size() - dn0, 1);
        if (nh == 3 && done_cyc_q.size() > dn0)
            chk({tag, "_done_timing"}, done_cyc_q[dn0] - hs_cyc_q[hs0 + 2], 1);
        if (nh > 0 && nr > 0)
            chk({tag, "_latency"}, hs_cyc_q[hs0] - rd_cyc_q[rd0], 3);
    endtask

    initial begin
        bit ok;
        int lat;
        vecs[0].x0 = 8'd1;   vecs[0].x1 = 8'd2;
        vecs[0].w  = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
        vecs[0].b  = {16'd1, 16'd1, 16'd1};
        vecs[0].y  = {16'd21, 16'd15, 16'd9};
        vecs[1].x0 = 8'd255; vecs[1].x1 = 8'd255;
        vecs[1].w  = {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        vecs[1].b  = {16'd1, 16'd1, 16'd1};
        vecs[1].y  = {16'd64515, 16'd64515, 16'd64515};
        vecs[2].x0 = 8'd3;   vecs[2].x1 = 8'd10;
        vecs[2].w  = {8'd7, 8'd100, 8'd255, 8'd0, 8'd2, 8'd1};
        vecs[2].b  = {16'd65535, 16'd1000, 16'd0};
        vecs[2].y  = {16'd369, 16'd3550, 16'd23};

        rst = 1'b1; start = 1'b0; x_valid = 1'b0; x_data = 8'd0; y_ready = 1'b0;
        s_start = 1'b0; s_x_valid = 1'b0; s_x_data = 8'd0; s_y_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_x_ready", x_ready, 0); chk("rst_w_rd_en", w_rd_en, 0);
        chk("rst_y_valid", y_valid, 0); chk("rst_w_addr", w_addr, 0);
        chk("rst_b_addr", b_addr, 0);   chk("rst_y_data", y_data, 0);
        chk("rst_y_idx", y_idx, 0);     chk("rst1_busy", s_busy, 0);
        rst = 1'b0;
        tick();
        chk("idle_x_ready", x_ready, 0);

        for (int i = 0; i < 3; i++) run_job(vecs[i], -1, 0, 1'b0, 1'b0, $sformatf("vec%0d", i));

        run_job(vecs[0], 1, 5, 1'b0, 1'b0, "stall");
        run_job(vecs[0], -1, 0, 1'b1, 1'b1, "proto");

        // Reset during row 1 MAC, then a clean job must give exact results.
        for (int i = 0; i < 6; i++) wmem[i] = vecs[0].w[i];
        for (int i = 0; i < 3; i++) bmem[i] = vecs[0].b[i];
        y_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_x(8'd1, "rmid");
        feed_x(8'd2, "rmid");
        x_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 30 && !ok; c++) begin
            tick();
            if (w_rd_en && w_addr == 3'd2) ok = 1'b1;
        end
        chk("rmid_reached_row1", ok, 1);
        rst = 1'b1;
        #1;
        chk("rmid_busy", busy, 0);       chk("rmid_done", done, 0);
        chk("rmid_x_ready", x_ready, 0); chk("rmid_w_rd_en", w_rd_en, 0);
        chk("rmid_y_valid", y_valid, 0); chk("rmid_w_addr", w_addr, 0);
        chk("rmid_b_addr", b_addr, 0);   chk("rmid_y_data", y_data, 0);
        chk("rmid_y_idx", y_idx, 0);
        tick(); tick();
        chk("rmid_hold_y_valid", y_valid, 0);
        rst = 1'b0;
        tick();
        run_job(vecs[0], -1, 0, 1'b0, 1'b0, "after_rst");

        // N=1, M=1: y = 5 + 3*4 = 17.
        s_y_ready = 1'b1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_x_valid = 1'b1;
        s_x_data  = 8'd3;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (s_x_ready) ok = 1'b1;
            tick();
        end
        chk("n1_x_accept", ok, 1);
        s_x_valid = 1'b0;
        ok = 1'b0; lat = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            tick();
            lat++;
            if (s_y_valid) ok = 1'b1;
        end
        chk("n1_y_valid_seen", ok, 1);
        chk("n1_latency", lat, 2);
        chk("n1_y_data", s_y_data, 17);
        chk("n1_y_idx", s_y_idx, 0);
        tick();
        chk("n1_done", s_done, 1);
        chk("n1_busy_in_done", s_busy, 1);
        chk("n1_y_valid_after", s_y_valid, 0);
        tick();
        chk("n1_done_after", s_done, 0);
        chk("n1_busy_after", s_busy, 0);
        chk("n1_read_count", s_rd_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
